// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and bit positions
package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_REG_COUNT   = 5'd9,
    CP0_REG_COMPARE = 5'd11,
    CP0_REG_SR      = 5'd12,
    CP0_REG_CAUSE   = 5'd13,
    CP0_REG_EPC     = 5'd14,
    CP0_REG_PRID    = 5'd15
  } cp0_reg_e;

  localparam logic [4:0] CP0_EXC_INT  = 5'd0;
  localparam logic [4:0] CP0_EXC_ADEL = 5'd4;
  localparam logic [4:0] CP0_EXC_ADES = 5'd5;
  localparam logic [4:0] CP0_EXC_RI   = 5'd10;
  localparam logic [4:0] CP0_EXC_OV   = 5'd12;

  localparam int CP0_BIT_IE  = 0;
  localparam int CP0_BIT_EXL = 1;
  localparam int CP0_BIT_BD  = 31;

  // A delay-slot victim restarts at its branch, one word earlier.
  function automatic logic [31:0] cp0_epc_calc(input logic [31:0] pc, input logic bd);
    return (bd ? (pc - 32'd4) : pc) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - pipeline <-> CP0 signal bundle (master = pipeline, slave = CP0)
interface cp0_unit_if #(
  parameter int NUM_HWINT = 6
);
  logic [4:0]           rd_addr;
  logic [4:0]           wr_addr;
  logic                 wr_en;
  logic [31:0]          wr_data;
  logic [31:0]          pc_m;
  logic                 bd_m;
  logic [4:0]           exc_code_m;
  logic                 eret_m;
  logic [NUM_HWINT-1:0] hw_int;
  logic [31:0]          rd_data;
  logic                 req;
  logic [31:0]          epc;
  logic                 exl;
  logic                 timer_irq;

  modport master (
    output rd_addr, wr_addr, wr_en, wr_data, pc_m, bd_m, exc_code_m, eret_m, hw_int,
    input  rd_data, req, epc, exl, timer_irq
  );

  modport slave (
    input  rd_addr, wr_addr, wr_en, wr_data, pc_m, bd_m, exc_code_m, eret_m, hw_int,
    output rd_data, req, epc, exl, timer_irq
  );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer; irq is sticky until Compare is rewritten
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        irq_q, irq_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    irq_d     = irq_q | (count_d == compare_q);
    // A Count load replaces this cycle's increment and its match check.
    if (wr_en_i && (wr_addr_i == CP0_REG_COUNT)) begin
      count_d = wr_data_i;
      irq_d   = irq_q;
    end
    if (wr_en_i && (wr_addr_i == CP0_REG_COMPARE)) begin
      compare_d = wr_data_i;
      irq_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 registers and M-stage exception/interrupt arbitration
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID      = 32'h0000_2019
) (
  input  logic     clk,
  input  logic     reset,
  cp0_unit_if.slave bus
);

  localparam int IP_LSB = 16 - NUM_HWINT;

  logic                 ie_q, ie_d;
  logic                 exl_q, exl_d;
  logic                 bd_q, bd_d;
  logic [4:0]           exc_q, exc_d;
  logic [31:0]          epc_q, epc_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  logic [NUM_HWINT-1:0] ip_q, ip_d;
  logic [NUM_HWINT-1:0] timer_line;

  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_irq;

  logic int_req, exc_req, req, wr_ok;
  logic [31:0] sr_val, cause_val, rd_data;

  always_comb begin
    int_req = ie_q & ~exl_q & (|(im_q & ip_q));
    exc_req = (bus.exc_code_m != 5'd0) & ~exl_q;
    req     = (int_req | exc_req) & ~reset;
    // A write colliding with a taken request is dropped so the handler entry wins.
    wr_ok   = bus.wr_en & ~req;
  end

  always_comb begin
    timer_line              = '0;
    timer_line[NUM_HWINT-1] = timer_irq;
    ip_d                    = bus.hw_int | timer_line;
  end

  always_comb begin
    ie_d  = ie_q;
    exl_d = exl_q;
    im_d  = im_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (wr_ok && (bus.wr_addr == CP0_REG_SR)) begin
      im_d  = bus.wr_data[IP_LSB +: NUM_HWINT];
      exl_d = bus.wr_data[CP0_BIT_EXL];
      ie_d  = bus.wr_data[CP0_BIT_IE];
    end
    if (wr_ok && (bus.wr_addr == CP0_REG_EPC)) begin
      epc_d = bus.wr_data;
    end
    if (req) begin
      exl_d = 1'b1;
      exc_d = int_req ? CP0_EXC_INT : bus.exc_code_m;
      bd_d  = bus.bd_m;
      epc_d = cp0_epc_calc(bus.pc_m, bus.bd_m);
    end else if (bus.eret_m) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im_q  <= '0;
      ip_q  <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      ie_q  <= ie_d;
      exl_q <= exl_d;
      im_q  <= im_d;
      ip_q  <= ip_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_ok),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .count_o   (count),
    .compare_o (compare),
    .irq_o     (timer_irq)
  );
`else
  assign count     = '0;
  assign compare   = '0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    sr_val                          = '0;
    sr_val[IP_LSB +: NUM_HWINT]     = im_q;
    sr_val[CP0_BIT_EXL]             = exl_q;
    sr_val[CP0_BIT_IE]              = ie_q;
    cause_val                       = '0;
    cause_val[IP_LSB +: NUM_HWINT]  = ip_q;
    cause_val[CP0_BIT_BD]           = bd_q;
    cause_val[6:2]                  = exc_q;
  end

  always_comb begin
    rd_data = '0;
    case (bus.rd_addr)
      CP0_REG_SR:      rd_data = sr_val;
      CP0_REG_CAUSE:   rd_data = cause_val;
      CP0_REG_EPC:     rd_data = epc_q;
      CP0_REG_PRID:    rd_data = PRID;
      CP0_REG_COUNT:   rd_data = count;
      CP0_REG_COMPARE: rd_data = compare;
      default:         rd_data = '0;
    endcase
  end

  assign bus.rd_data   = rd_data;
  assign bus.req       = req;
  assign bus.epc       = epc_q;
  assign bus.exl       = exl_q;
  assign bus.timer_irq = timer_irq;

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed self-checking bench for cp0_unit
module tb_cp0_unit;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #10 clk = ~clk;

  cp0_unit_if #(.NUM_HWINT(6)) bus ();

  cp0_unit #(
    .NUM_HWINT (6),
    .PRID      (32'h0000_2019)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.rd_addr = a;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    bus.rd_addr    = '0;
    bus.wr_addr    = '0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.pc_m       = '0;
    bus.bd_m       = 1'b0;
    bus.exc_code_m = '0;
    bus.eret_m     = 1'b0;
    bus.hw_int     = '0;
    tick();
    tick();
    bus.exc_code_m = 5'd12;
    #1;
    check("req_low_in_reset", {31'd0, bus.req}, 32'd0);
    bus.exc_code_m = 5'd0;
    reset = 1'b0;
    tick();

    rd_check(5'd12, 32'h0, "sr_reset");
    rd_check(5'd13, 32'h0, "cause_reset");
    rd_check(5'd14, 32'h0, "epc_reset");
    rd_check(5'd15, 32'h0000_2019, "prid");
    rd_check(5'd3,  32'h0, "unmapped");
    check("req_reset", {31'd0, bus.req}, 32'd0);
    check("exl_reset", {31'd0, bus.exl}, 32'd0);
    check("timer_irq_reset", {31'd0, bus.timer_irq}, 32'd0);

    // Interrupt enabled by SR write, line 2 -> IP bit 12
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd12;
    bus.wr_data = 32'h0000_FC01;
    bus.hw_int  = 6'b000100;
    #1;
    check("hw_int_latency0", {31'd0, bus.req}, 32'd0);
    tick();
    bus.wr_en = 1'b0;
    bus.pc_m  = 32'h0000_1000;
    bus.bd_m  = 1'b0;
    #1;
    check("int_req", {31'd0, bus.req}, 32'd1);
    rd_check(5'd12, 32'h0000_FC01, "sr_written");
    tick();
    check("exl_masks_req", {31'd0, bus.req}, 32'd0);
    check("exl_set_int", {31'd0, bus.exl}, 32'd1);
    rd_check(5'd13, 32'h0000_1000, "cause_int");
    check("epc_int", bus.epc, 32'h0000_1000);
    rd_check(5'd12, 32'h0000_FC03, "sr_exl");
    bus.hw_int = '0;
    bus.eret_m = 1'b1;
    tick();
    bus.eret_m = 1'b0;
    check("eret_clears_exl", {31'd0, bus.exl}, 32'd0);
    check("req_after_eret", {31'd0, bus.req}, 32'd0);

    // Delay-slot exception, combinational req
    bus.exc_code_m = 5'd12;
    bus.bd_m       = 1'b1;
    bus.pc_m       = 32'h0000_3010;
    #1;
    check("exc_req_comb", {31'd0, bus.req}, 32'd1);
    tick();
    bus.exc_code_m = 5'd0;
    bus.bd_m       = 1'b0;
    check("epc_bd", bus.epc, 32'h0000_300C);
    rd_check(5'd13, 32'h8000_0030, "cause_bd_ov");
    check("exl_set_exc", {31'd0, bus.exl}, 32'd1);

    // Exception blocked while EXL, then eret
    bus.exc_code_m = 5'd4;
    #1;
    check("exc_masked_exl", {31'd0, bus.req}, 32'd0);
    bus.exc_code_m = 5'd0;
    bus.eret_m     = 1'b1;
    tick();
    bus.eret_m = 1'b0;
    check("eret_exl0", {31'd0, bus.exl}, 32'd0);
    check("eret_epc_kept", bus.epc, 32'h0000_300C);

    // EPC fully writable, Cause read-only
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd14;
    bus.wr_data = 32'h1234_5677;
    tick();
    check("epc_mtc0", bus.epc, 32'h1234_5677);
    bus.wr_addr = 5'd13;
    bus.wr_data = 32'hFFFF_FFFF;
    tick();
    bus.wr_en = 1'b0;
    rd_check(5'd13, 32'h8000_0030, "cause_readonly");

    // Interrupt + exception + mtc0 EPC in one cycle
    bus.hw_int = 6'b000001;
    tick();
    bus.exc_code_m = 5'd5;
    bus.pc_m       = 32'h0000_2000;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 5'd14;
    bus.wr_data    = 32'hDEAD_BEEF;
    #1;
    check("int_exc_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.wr_en      = 1'b0;
    bus.exc_code_m = 5'd0;
    rd_check(5'd13, 32'h0000_0400, "cause_int_priority");
    check("epc_write_dropped", bus.epc, 32'h0000_2000);
    bus.hw_int = '0;
    bus.eret_m = 1'b1;
    tick();
    bus.eret_m = 1'b0;

    // Reset mid-handler
    bus.exc_code_m = 5'd10;
    bus.pc_m       = 32'h0000_4000;
    tick();
    check("exl_before_reset", {31'd0, bus.exl}, 32'd1);
    reset = 1'b1;
    #1;
    check("req_low_reset_mid", {31'd0, bus.req}, 32'd0);
    tick();
    check("exl_after_reset", {31'd0, bus.exl}, 32'd0);
    check("epc_after_reset", bus.epc, 32'h0);
    rd_check(5'd13, 32'h0, "cause_after_reset");
    rd_check(5'd12, 32'h0, "sr_after_reset");
    reset          = 1'b0;
    bus.exc_code_m = 5'd0;
    tick();

`ifdef CP0_TIMER_EN
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd12;
    bus.wr_data = 32'h0000_8001;
    tick();
    bus.wr_addr = 5'd11;
    bus.wr_data = 32'd5;
    tick();
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'd0;
    tick();
    bus.wr_en = 1'b0;
    rd_check(5'd9,  32'd0, "count_loaded");
    rd_check(5'd11, 32'd5, "compare_written");
    check("timer_irq_idle", {31'd0, bus.timer_irq}, 32'd0);
    repeat (4) tick();
    check("timer_irq_count4", {31'd0, bus.timer_irq}, 32'd0);
    rd_check(5'd9, 32'd4, "count4");
    tick();
    check("timer_irq_match", {31'd0, bus.timer_irq}, 32'd1);
    check("timer_req_lat0", {31'd0, bus.req}, 32'd0);
    rd_check(5'd9, 32'd5, "count5");
    tick();
    check("timer_req", {31'd0, bus.req}, 32'd1);
    tick();
    check("timer_exl", {31'd0, bus.exl}, 32'd1);
    rd_check(5'd13, 32'h0000_8000, "cause_timer");
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd11;
    bus.wr_data = 32'd100;
    tick();
    bus.wr_en = 1'b0;
    check("timer_irq_cleared", {31'd0, bus.timer_irq}, 32'd0);
`else
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd11;
    bus.wr_data = 32'd5;
    tick();
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'd7;
    tick();
    bus.wr_en = 1'b0;
    rd_check(5'd11, 32'd0, "compare_absent");
    rd_check(5'd9,  32'd0, "count_absent");
    check("timer_irq_tied", {31'd0, bus.timer_irq}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
